// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg : shared types for the pipeline redirect controller
// Revision: 1.0
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RS = 2'd1,
    HOLD    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ID   = 2'd1,
    SRC_EX   = 2'd2
  } src_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/redirect_hold_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// redirect_hold_reg : keeps a redirect target and its source until fetch
//                     accepts it. A load always wins over a release.
// Revision: 1.0
// ---------------------------------------------------------------------------
module redirect_hold_reg
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  src_t        load_src,
  input  logic        release_hold,
  output logic [31:0] held_addr,
  output src_t        held_src
);

  always_ff @(posedge clk) begin
    if (rst) begin
      held_addr <= RESET_PC;
      held_src  <= SRC_NONE;
    end else if (load) begin
      held_addr <= load_addr;
      held_src  <= load_src;
    end else if (release_hold) begin
      held_addr <= RESET_PC;
      held_src  <= SRC_NONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jump_redirect_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jump_redirect_ctrl : picks one PC redirect per cycle (EX branch over ID
//                      jump/JR), stalls on busy JR sources, holds until fetch.
// Revision: 1.0
// ---------------------------------------------------------------------------
module jump_redirect_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 7,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic [31:0]      id_jtarget,
  input  logic [31:0]      id_rs_data,
  input  logic             id_rs_busy,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_addr,
  output logic             flush_if,
  output logic             flush_id,
  output logic             stall_id,
  output logic             err_timeout,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int          WAIT_W     = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;

  logic              hold_load;
  logic [31:0]       hold_load_addr;
  src_t              hold_load_src;
  logic              hold_release;
  logic [31:0]       held_addr;
  src_t              held_src;

  redirect_hold_reg u_hold (
    .clk          (clk),
    .rst          (rst),
    .load         (hold_load),
    .load_addr    (hold_load_addr),
    .load_src     (hold_load_src),
    .release_hold (hold_release),
    .held_addr    (held_addr),
    .held_src     (held_src)
  );

  always_comb begin
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    stall_id       = 1'b0;
    err_timeout    = 1'b0;
    next_state     = state;
    wait_next      = wait_cnt;
    hold_load      = 1'b0;
    hold_load_addr = ex_br_target;
    hold_load_src  = SRC_EX;
    hold_release   = 1'b0;

    case (state)
      IDLE: begin
        if (ex_br_taken) begin
          redirect_valid = 1'b1;
          redirect_addr  = ex_br_target;
          flush_if       = 1'b1;
          flush_id       = 1'b1;
          if (!fetch_ready) begin
            hold_load  = 1'b1;
            next_state = HOLD;
          end
        end else if (id_valid && id_jump) begin
          // The jump itself continues down the pipe for the JAL link write.
          redirect_valid = 1'b1;
          redirect_addr  = id_jtarget;
          flush_if       = 1'b1;
          if (!fetch_ready) begin
            hold_load      = 1'b1;
            hold_load_addr = id_jtarget;
            hold_load_src  = SRC_ID;
            next_state     = HOLD;
          end
        end else if (id_valid && id_jr) begin
          if (!id_rs_busy) begin
            redirect_valid = 1'b1;
            redirect_addr  = id_rs_data;
            flush_if       = 1'b1;
            if (!fetch_ready) begin
              hold_load      = 1'b1;
              hold_load_addr = id_rs_data;
              hold_load_src  = SRC_ID;
              next_state     = HOLD;
            end
          end else begin
            stall_id   = 1'b1;
            wait_next  = '0;
            next_state = WAIT_RS;
          end
        end
      end

      WAIT_RS: begin
        if (ex_br_taken) begin
          redirect_valid = 1'b1;
          redirect_addr  = ex_br_target;
          flush_if       = 1'b1;
          flush_id       = 1'b1;
          if (fetch_ready) begin
            next_state = IDLE;
          end else begin
            hold_load  = 1'b1;
            next_state = HOLD;
          end
        end else if (id_rs_busy) begin
          stall_id = 1'b1;
          // Saturation keeps err_timeout to a single pulse per wait.
          if (wait_cnt < WAIT_LIMIT) begin
            wait_next = wait_cnt + 1'b1;
            if (wait_cnt + 1'b1 == WAIT_LIMIT) begin
              err_timeout = 1'b1;
            end
          end
        end else begin
          redirect_valid = 1'b1;
          redirect_addr  = id_rs_data;
          flush_if       = 1'b1;
          if (fetch_ready) begin
            next_state = IDLE;
          end else begin
            hold_load      = 1'b1;
            hold_load_addr = id_rs_data;
            hold_load_src  = SRC_ID;
            next_state     = HOLD;
          end
        end
      end

      HOLD: begin
        redirect_valid = 1'b1;
        flush_if       = 1'b1;
        stall_id       = 1'b1;
        if (ex_br_taken) begin
          redirect_addr = ex_br_target;
          flush_id      = 1'b1;
          if (fetch_ready) begin
            hold_release = 1'b1;
            next_state   = IDLE;
          end else begin
            hold_load = 1'b1;
          end
        end else begin
          redirect_addr = held_addr;
          flush_id      = (held_src == SRC_EX);
          if (fetch_ready) begin
            hold_release = 1'b1;
            next_state   = IDLE;
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    // Reset overrides any request presented during the same cycle.
    if (rst) begin
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      flush_if       = 1'b0;
      flush_id       = 1'b0;
      stall_id       = 1'b0;
      err_timeout    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt <= '0;
    end else if (redirect_valid && fetch_ready) begin
      redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/jump_redirect_ctrl.md
Name: jump_redirect_ctrl

Overview:
- Sequences control-flow redirects for the 5-stage pipeline.
- Takes jump requests from ID (J/JAL absolute target, JR register target) and resolved taken branches from EX. It chooses one redirect per cycle, stalls ID while a JR source register is not yet forwardable, and flushes the younger stages.
- It holds a pending redirect until the fetch side accepts it.
- It sits between the hazard unit, the jump-address datapath and the PC register.

Parameters:
- WAIT_MAX, 7, cycles a JR may wait for its operand before err_timeout pulses. Waiting continues after the pulse.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_jump  in  1  ID instruction is J/JAL
- id_jr  in  1  ID instruction is JR/JALR
- id_jtarget  in  32  {pc_plus4[31:28], target, 2'b00} from the jump datapath
- id_rs_data  in  32  forwarded rs value
- id_rs_busy  in  1  rs not yet forwardable (load in EX/MEM)
- ex_br_taken  in  1  EX resolved taken branch
- ex_br_target  in  32  branch target
- fetch_ready  in  1  PC/IF can accept a redirect this cycle
- redirect_valid  out  1  drive PC mux to redirect_addr
- redirect_addr  out  32  new PC
- flush_if  out  1  squash IF/ID register
- flush_id  out  1  squash ID/EX register
- stall_id  out  1  hold PC and IF/ID
- err_timeout  out  1  one-cycle pulse
- redirect_cnt  out  CNT_W  accepted redirects, wraps

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - State goes to IDLE.
  - All outputs go to 0; redirect_addr goes to 0; counters clear.
  - rst dominates every other input on the same edge.
- States: IDLE, WAIT_RS, HOLD.
- Request priority, evaluated every cycle in IDLE: EX branch > ID jump/JR. The EX instruction is older, so its redirect wins and the ID instruction is flushed.
- IDLE, ex_br_taken=1:
  - Combinationally set redirect_valid=1, redirect_addr=ex_br_target, flush_if=1, flush_id=1.
  - If fetch_ready=1: count it and stay in IDLE.
  - If fetch_ready=0: latch the target and go to HOLD.
- IDLE, id_valid & id_jump:
  - Set redirect_valid=1, redirect_addr=id_jtarget, flush_if=1. flush_id=0, because the jump itself proceeds (JAL link).
  - fetch_ready=0 goes to HOLD.
- IDLE, id_valid & id_jr:
  - If id_rs_busy=0: same as id_jump but using id_rs_data.
  - If id_rs_busy=1: stall_id=1, no redirect, go to WAIT_RS, clear the wait counter.
- If id_jump and id_jr are both set, id_jr is ignored and the jump is taken.
- WAIT_RS:
  - stall_id=1 while id_rs_busy=1. The wait counter increments, saturating at WAIT_MAX.
  - err_timeout pulses exactly once, on the cycle the counter reaches WAIT_MAX.
  - When id_rs_busy drops: same cycle redirect with id_rs_data, stall_id=0, flush_if=1. Then go to IDLE, or to HOLD if fetch_ready=0.
  - An ex_br_taken arriving in WAIT_RS preempts the JR: redirect to the branch, flush_if=flush_id=1, abandon the wait.
- HOLD:
  - Outputs come from the latched address: redirect_valid=1, flush_if=1, stall_id=1.
  - flush_id=1 only if the held redirect came from EX.
  - On fetch_ready=1: count it and go to IDLE.
  - A new ex_br_taken in HOLD replaces the latched address (newer resolution of an older path) and sets the flush_id flag.
  - ID requests are ignored in HOLD.
- redirect_cnt increments by 1 per accepted redirect (redirect_valid & fetch_ready) and wraps modulo 2^CNT_W.
- Addresses pass through unmodified; no alignment checks.
- Latency:
  - Unstalled redirect: 0 cycles, combinational from request to redirect_valid.
  - JR waiting N busy cycles redirects on cycle N+1.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (IDLE/WAIT_RS/HOLD)
  - redirect-source encoding (SRC_NONE/SRC_ID/SRC_EX)
  - the reset PC constant
- One natural sub-module: redirect_hold_reg, which latches addr plus source and releases on fetch_ready.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_br_taken=1 -> all outputs 0, redirect_cnt=0 after release.
- J: id_valid=1, id_jump=1, id_jtarget=0x0040_0100, fetch_ready=1 -> same cycle redirect_valid=1, addr=0x0040_0100, flush_if=1, flush_id=0, redirect_cnt=1.
- JR with load-use: id_jr=1, id_rs_busy=1 for 2 cycles, id_rs_data=0x1000_0020 -> stall_id=1 for 2 cycles, redirect on 3rd cycle to 0x1000_0020, no err_timeout.
- Timeout: id_rs_busy held 9 cycles, WAIT_MAX=7 -> err_timeout single pulse on 7th wait cycle, redirect after busy drops.
- Priority: ex_br_taken=1 (0x0000_0800) with id_jump=1 (0x0000_0400) -> addr=0x0000_0800, flush_if=flush_id=1, ID jump squashed.
- Hold: fetch_ready=0 for 3 cycles after a J redirect, then an EX branch to 0x0000_0900 in cycle 2 -> redirect_addr switches to 0x0000_0900 with flush_id=1, released when fetch_ready=1, counter +1 only.
